// File: rtl/tsv_link_pkg.sv
// rtl/tsv_link_pkg.sv - shared definitions for the inter-layer TSV serial link
// Purpose: state encoding, frame defaults, line levels and the parity helper
//   shared by the TSV transmitter and receiver.
// Ports: none (package).
package tsv_link_pkg;

  localparam int          FRAME_W_DEF   = 32;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hBEEF;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } link_state_t;

  // Even parity over a zero-extended frame; the zero fill does not change the XOR.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tsv_frame_tx.sv
// rtl/tsv_frame_tx.sv - framed serial transmitter for the inter-layer TSV link
// Purpose: latch a frame on a one-cycle request and shift it out as
//   start bit, FRAME_W data bits MSB first, even parity, stop bit, idle gap.
// Ports:
//   div_8_clk  in   clock
//   rst_n      in   synchronous active-low reset
//   tx_req     in   one-cycle send request, data_in valid alongside
//   data_in    in   frame to send
//   ser_out    out  serial line, idle high
//   busy       out  high while a frame occupies the transmitter
//   frame_sent out  one-cycle pulse after the stop bit
//   bad_req    out  one-cycle pulse for a request failing the sync check
//   drop_cnt   out  saturating count of requests ignored while busy
module tsv_frame_tx
  import tsv_link_pkg::*;
#(
  parameter int          FRAME_W    = FRAME_W_DEF,
  parameter int          GAP_CYC    = 2,
  parameter bit          CHECK_SYNC = 1'b1,
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEF
) (
  input  logic               div_8_clk,
  input  logic               rst_n,
  input  logic               tx_req,
  input  logic [FRAME_W-1:0] data_in,
  output logic               ser_out,
  output logic               busy,
  output logic               frame_sent,
  output logic               bad_req,
  output logic [3:0]         drop_cnt
);

  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  // A zero-cycle gap still needs a legal 1-bit counter; it is simply never loaded usefully.
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  link_state_t        state, next_state;
  logic [FRAME_W-1:0] shift_q;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               parity_q;

  logic               sync_ok;
  logic               accept;

  logic               ser_out_d;
  logic               busy_d;
  logic               frame_sent_d;
  logic               bad_req_d;
  logic [3:0]         drop_cnt_d;

  assign sync_ok = !CHECK_SYNC || (data_in[15:0] == SYNC_WORD);
  assign accept  = (state == ST_IDLE) && tx_req && sync_ok;

  // State register plus every registered output and datapath element.
  always_ff @(posedge div_8_clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ser_out    <= IDLE_LVL;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
      bad_req    <= 1'b0;
      drop_cnt   <= 4'd0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      parity_q   <= 1'b0;
    end else begin
      state      <= next_state;
      ser_out    <= ser_out_d;
      busy       <= busy_d;
      frame_sent <= frame_sent_d;
      bad_req    <= bad_req_d;
      drop_cnt   <= drop_cnt_d;

      if (accept) begin
        shift_q  <= data_in;
        parity_q <= even_parity(64'(data_in));
        bit_cnt  <= BIT_W'(FRAME_W - 1);
      end else if (next_state == ST_DATA) begin
        // The bit driven onto the line this edge is the MSB being shifted out.
        shift_q <= shift_q << 1;
      end

      if (state == ST_DATA && bit_cnt != '0)
        bit_cnt <= bit_cnt - BIT_W'(1);

      if (state == ST_STOP)
        gap_cnt <= GAP_W'(GAP_CYC - 1);
      else if (state == ST_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_START;
      ST_START:  next_state = ST_DATA;
      ST_DATA:   if (bit_cnt == '0) next_state = ST_PARITY;
      ST_PARITY: next_state = ST_STOP;
      ST_STOP:   next_state = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:    if (gap_cnt == '0) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output logic: values computed for the upcoming state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    ser_out_d    = IDLE_LVL;
    busy_d       = (next_state != ST_IDLE);
    frame_sent_d = (state == ST_STOP);
    bad_req_d    = (state == ST_IDLE) && tx_req && !sync_ok;
    drop_cnt_d   = drop_cnt;

    case (next_state)
      ST_START:  ser_out_d = START_BIT;
      ST_DATA:   ser_out_d = shift_q[FRAME_W-1];
      ST_PARITY: ser_out_d = parity_q;
      ST_STOP:   ser_out_d = STOP_BIT;
      default:   ser_out_d = IDLE_LVL;
    endcase

    // Includes the last busy cycle before IDLE: that request is dropped too.
    if (state != ST_IDLE && tx_req && drop_cnt != 4'hF)
      drop_cnt_d = drop_cnt + 4'd1;
  end

endmodule

// File: tb/tb_tsv_frame_tx.sv
// tb/tb_tsv_frame_tx.sv - self-checking bench for tsv_frame_tx
// Purpose: directed frames on three parameterisations with a serial-bit scoreboard.
// Ports: none (top-level bench).
module tb_tsv_frame_tx;

  logic        clk;
  logic        rst_n;
  logic        tx_req     [3];
  logic [31:0] data_in    [3];
  logic        ser_out    [3];
  logic        busy       [3];
  logic        frame_sent [3];
  logic        bad_req    [3];
  logic [3:0]  drop_cnt   [3];

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  // 0: GAP_CYC=2, sync checked; 1: sync check off; 2: no gap.
  tsv_frame_tx #(.FRAME_W(32), .GAP_CYC(2), .CHECK_SYNC(1'b1), .SYNC_WORD(16'hBEEF)) u_dut (
    .div_8_clk(clk), .rst_n(rst_n), .tx_req(tx_req[0]), .data_in(data_in[0]),
    .ser_out(ser_out[0]), .busy(busy[0]), .frame_sent(frame_sent[0]),
    .bad_req(bad_req[0]), .drop_cnt(drop_cnt[0]));

  tsv_frame_tx #(.FRAME_W(32), .GAP_CYC(2), .CHECK_SYNC(1'b0), .SYNC_WORD(16'hBEEF)) u_nosync (
    .div_8_clk(clk), .rst_n(rst_n), .tx_req(tx_req[1]), .data_in(data_in[1]),
    .ser_out(ser_out[1]), .busy(busy[1]), .frame_sent(frame_sent[1]),
    .bad_req(bad_req[1]), .drop_cnt(drop_cnt[1]));

  tsv_frame_tx #(.FRAME_W(32), .GAP_CYC(0), .CHECK_SYNC(1'b1), .SYNC_WORD(16'hBEEF)) u_nogap (
    .div_8_clk(clk), .rst_n(rst_n), .tx_req(tx_req[2]), .data_in(data_in[2]),
    .ser_out(ser_out[2]), .busy(busy[2]), .frame_sent(frame_sent[2]),
    .bad_req(bad_req[2]), .drop_cnt(drop_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge. Issues one request, scoreboards the whole
  // frame plus one trailing idle cycle. noise floods requests while busy;
  // abort_at asserts reset right after that sample index and returns.
  task automatic send_frame(input int i, input logic [31:0] d, input int gap,
                            input bit noise, input int abort_at);
    logic exp_bit;
    int   n;
    exp_q.delete();
    tx_req[i]  = 1'b1;
    data_in[i] = d;
    exp_q.push_back(1'b0);
    for (int b = 31; b >= 0; b--) exp_q.push_back(d[b]);
    exp_q.push_back(^d);
    exp_q.push_back(1'b1);
    for (int g = 0; g < gap; g++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    n = exp_q.size();
    @(posedge clk);
    #1 tx_req[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp_bit = exp_q.pop_front();
      check($sformatf("ser_out u%0d k%0d", i, k), 32'(ser_out[i]), 32'(exp_bit));
      check($sformatf("busy u%0d k%0d", i, k), 32'(busy[i]), 32'(k < 35 + gap));
      check($sformatf("frame_sent u%0d k%0d", i, k), 32'(frame_sent[i]), 32'(k == 35));
      if (noise) begin
        if (k == 10) check("drop_cnt mid", 32'(drop_cnt[i]), 32'd10);
        tx_req[i]  = (k < 20);
        data_in[i] = $urandom();
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_req[i]  = 1'b0;
      data_in[i] = 32'h0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst ser_out u%0d", i), 32'(ser_out[i]), 32'd1);
      check($sformatf("rst busy u%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst frame_sent u%0d", i), 32'(frame_sent[i]), 32'd0);
      check($sformatf("rst bad_req u%0d", i), 32'(bad_req[i]), 32'd0);
      check($sformatf("rst drop_cnt u%0d", i), 32'(drop_cnt[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic frame, parity 0, two gap cycles
    send_frame(0, 32'hA112_BEEF, 2, 1'b0, -1);
    check("t1 parity const", 32'(^(32'hA112_BEEF)), 32'd0);

    // 2: sync check disabled, parity 1
    send_frame(1, 32'hA000_0001, 2, 1'b0, -1);
    check("t2 drop_cnt", 32'(drop_cnt[1]), 32'd0);

    // 3: sync failure
    tx_req[0]  = 1'b1;
    data_in[0] = 32'h1234_5678;
    @(posedge clk);
    #1 tx_req[0] = 1'b0;
    @(negedge clk);
    check("t3 bad_req pulse", 32'(bad_req[0]), 32'd1);
    check("t3 busy", 32'(busy[0]), 32'd0);
    check("t3 ser_out", 32'(ser_out[0]), 32'd1);
    @(negedge clk);
    check("t3 bad_req clear", 32'(bad_req[0]), 32'd0);
    check("t3 busy after", 32'(busy[0]), 32'd0);
    check("t3 ser_out after", 32'(ser_out[0]), 32'd1);
    check("t3 drop_cnt", 32'(drop_cnt[0]), 32'd0);

    // 4: flood of requests while busy, saturating drop counter
    send_frame(0, 32'h5A5A_BEEF, 2, 1'b1, -1);
    check("t4 drop_cnt sat", 32'(drop_cnt[0]), 32'd15);

    // 5: reset at the 10th data bit aborts the frame
    send_frame(0, 32'hC3C3_BEEF, 2, 1'b0, 10);
    @(negedge clk);
    check("t5 ser_out", 32'(ser_out[0]), 32'd1);
    check("t5 busy", 32'(busy[0]), 32'd0);
    check("t5 drop_cnt", 32'(drop_cnt[0]), 32'd0);
    check("t5 frame_sent", 32'(frame_sent[0]), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check($sformatf("t5 idle frame_sent k%0d", k), 32'(frame_sent[0]), 32'd0);
      check($sformatf("t5 idle ser_out k%0d", k), 32'(ser_out[0]), 32'd1);
    end
    send_frame(0, 32'h0F0F_BEEF, 2, 1'b0, -1);

    // 6: no gap, back-to-back at the first IDLE cycle
    send_frame(2, 32'h0000_BEEF, 0, 1'b0, -1);
    send_frame(2, 32'hFFFF_BEEF, 0, 1'b0, -1);
    check("t6 drop_cnt", 32'(drop_cnt[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
